// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM state
// encoding and the address-geometry helpers used to size the tag/index/offset fields.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE_BACK = 2'd1,
    ST_FETCH      = 2'd2,
    ST_FILL       = 2'd3
  } dcache_state_e;

  function automatic int dcache_off_w(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int dcache_idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int dcache_tag_w(input int addr_w, input int num_sets,
                                      input int words_per_block);
    return addr_w - $clog2(num_sets) - $clog2(words_per_block);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for the data cache: valid/dirty/tag/block per set, one
// combinational read port, a single-word write port and a whole-block fill port.
module dcache_line_array import dcache_pkg::*; #(
  parameter  int DATA_W          = 8,
  parameter  int NUM_SETS        = 8,
  parameter  int WORDS_PER_BLOCK = 4,
  parameter  int TAG_W           = 3,
  localparam int OFF_W           = dcache_off_w(WORDS_PER_BLOCK),
  localparam int IDX_W           = dcache_idx_w(NUM_SETS),
  localparam int BLK_W           = DATA_W * WORDS_PER_BLOCK
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [BLK_W-1:0]  rd_block,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [BLK_W-1:0]  fill_block
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [BLK_W-1:0]    data_q [NUM_SETS];
  logic [BLK_W-1:0]    data_d [NUM_SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_block = data_q[rd_idx];

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      data_d[wr_idx][int'(wr_off)*DATA_W +: DATA_W] = wr_data;
      dirty_d[wr_idx] = 1'b1;
    end
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
      dirty_d[fill_idx] = 1'b0;
      tag_d[fill_idx]   = fill_tag;
      data_d[fill_idx]  = fill_block;
    end
  end

  // NOTE: flops take non-blocking updates so every register samples pre-edge values regardless of block order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag and data arrays are deliberately left unreset; the valid bits alone say whether they mean anything.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller between the CPU
// port and a block-wide memory. Optional hit/miss counters under `CACHE_STATS_EN`.
module dcache_ctrl import dcache_pkg::*; #(
  parameter  int DATA_W          = 8,
  parameter  int ADDR_W          = 8,
  parameter  int NUM_SETS        = 8,
  parameter  int WORDS_PER_BLOCK = 4,
  localparam int OFF_W           = dcache_off_w(WORDS_PER_BLOCK),
  localparam int IDX_W           = dcache_idx_w(NUM_SETS),
  localparam int TAG_W           = dcache_tag_w(ADDR_W, NUM_SETS, WORDS_PER_BLOCK),
  localparam int BLK_W           = DATA_W * WORDS_PER_BLOCK
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    READ,
  input  logic                    WRITE,
  input  logic [ADDR_W-1:0]       ADDRESS,
  input  logic [DATA_W-1:0]       WRITEDATA,
  output logic [DATA_W-1:0]       READDATA,
  output logic                    BUSYWAIT,
  output logic                    MEM_READ,
  output logic                    MEM_WRITE,
  output logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS,
  output logic [BLK_W-1:0]        MEM_WRITEDATA,
  input  logic [BLK_W-1:0]        MEM_READDATA,
  input  logic                    MEM_BUSYWAIT
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]             HIT_COUNT,
  output logic [15:0]             MISS_COUNT
`endif
);

  localparam logic [1:0] IDLE       = ST_IDLE;
  localparam logic [1:0] WRITE_BACK = ST_WRITE_BACK;
  localparam logic [1:0] FETCH      = ST_FETCH;
  localparam logic [1:0] FILL       = ST_FILL;

  logic [1:0]              state_q, state_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_W-OFF_W-1:0] mem_address_q, mem_address_d;
  logic [BLK_W-1:0]        mem_writedata_q, mem_writedata_d;
  logic [BLK_W-1:0]        fill_data_q, fill_data_d;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             line_valid, line_dirty;
  logic [TAG_W-1:0] line_tag;
  logic [BLK_W-1:0] line_block;
  logic             req, hit, idle, serve, wr_en, fill_en;

  assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_idx = ADDRESS[OFF_W +: IDX_W];
  assign addr_off = ADDRESS[OFF_W-1:0];

  // A request seen while RESET is high is ignored so nothing is served or written mid-reset.
  assign req     = (READ | WRITE) & ~RESET;
  assign hit     = line_valid && (line_tag == addr_tag);
  assign idle    = (state_q == IDLE);
  assign serve   = idle && req && hit;
  assign wr_en   = serve && WRITE;
  assign fill_en = (state_q == FILL) && !RESET;

  assign READDATA = (serve && !WRITE) ? line_block[int'(addr_off)*DATA_W +: DATA_W] : '0;
  assign BUSYWAIT = !idle || (req && !hit);

  dcache_line_array #(
    .DATA_W          (DATA_W),
    .NUM_SETS        (NUM_SETS),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .TAG_W           (TAG_W)
  ) u_lines (
    .CLK        (CLK),
    .RESET      (RESET),
    .rd_idx     (addr_idx),
    .rd_valid   (line_valid),
    .rd_dirty   (line_dirty),
    .rd_tag     (line_tag),
    .rd_block   (line_block),
    .wr_en      (wr_en),
    .wr_idx     (addr_idx),
    .wr_off     (addr_off),
    .wr_data    (WRITEDATA),
    .fill_en    (fill_en),
    .fill_idx   (addr_idx),
    .fill_tag   (addr_tag),
    .fill_block (fill_data_q)
  );

  always_comb begin
    state_d     = state_q;
    fill_data_d = fill_data_q;
    case (state_q)
      IDLE:       if (req && !hit) state_d = (line_valid && line_dirty) ? WRITE_BACK : FETCH;
      WRITE_BACK: if (!MEM_BUSYWAIT) state_d = FETCH;
      FETCH: begin
        if (!MEM_BUSYWAIT) begin
          state_d     = FILL;
          fill_data_d = MEM_READDATA;
        end
      end
      FILL:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // Memory-side outputs are registered decodes of the next state.
    mem_read_d      = (state_d == FETCH);
    mem_write_d     = (state_d == WRITE_BACK);
    mem_address_d   = '0;
    mem_writedata_d = '0;
    if (state_d == WRITE_BACK) begin
      mem_address_d   = {line_tag, addr_idx};
      mem_writedata_d = line_block;
    end else if (state_d == FETCH) begin
      mem_address_d   = {addr_tag, addr_idx};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  always_ff @(posedge CLK) begin
    fill_data_q <= fill_data_d;
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;

`ifdef CACHE_STATS_EN
  logic        refill_q, refill_d;
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // refill_q marks the IDLE cycle right after FILL, whose hit belongs to the miss already counted.
  always_comb begin
    refill_d     = (state_q == FILL);
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (serve && !refill_q && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
    if (idle && state_d != IDLE && miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      refill_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat-memory reference plus a per-set tag model
// predict read data, stall lengths and memory transfers; monitors pop and compare.
module tb_dcache_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int BLK_W  = 32;
  localparam int MA_W   = 6;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              READ, WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;
  logic              MEM_READ, MEM_WRITE;
  logic [MA_W-1:0]   MEM_ADDRESS;
  logic [BLK_W-1:0]  MEM_WRITEDATA;
  logic [BLK_W-1:0]  MEM_READDATA;
  logic              MEM_BUSYWAIT;
`ifdef CACHE_STATS_EN
  logic [15:0]       HIT_COUNT, MISS_COUNT;
`endif

  always #5 CLK = ~CLK;

  dcache_ctrl #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_SETS (8), .WORDS_PER_BLOCK (4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef CACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  typedef struct {
    bit              is_wb;
    logic [MA_W-1:0] addr;
    logic [31:0]     data;
  } mem_ev_t;

  mem_ev_t     exp_mem[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  ref_mem[256];
  logic [7:0]  bmem[256];
  bit          mvalid[8];
  bit          mdirty[8];
  logic [2:0]  mtag[8];
  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          exp_hits = 0;
  int          exp_misses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event observed with nothing expected", name);
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, "_hit_count"},  HIT_COUNT,  (exp_hits   > 65535) ? 65535 : exp_hits);
    check({tag, "_miss_count"}, MISS_COUNT, (exp_misses > 65535) ? 65535 : exp_misses);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Block-wide memory with a programmable latency; it also checks each transfer it completes.
  initial begin
    int cnt;
    mem_ev_t ev;
    cnt = 0;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    forever begin
      @(negedge CLK);
      if (MEM_READ === 1'b1 || MEM_WRITE === 1'b1) begin
        check("mem_req_overlap", MEM_READ & MEM_WRITE, 0);
        cnt++;
        if (cnt >= lat) begin
          MEM_BUSYWAIT = 1'b0;
          cnt = 0;
          if (exp_mem.size() == 0) fail("mem_unexpected_transfer");
          else begin
            ev = exp_mem.pop_front();
            check("mem_kind_is_wb", MEM_WRITE, ev.is_wb);
            check("mem_address", MEM_ADDRESS, ev.addr);
            if (ev.is_wb) check("mem_wb_data", MEM_WRITEDATA, ev.data);
          end
          for (int w = 0; w < 4; w++) begin
            if (MEM_WRITE) bmem[{MEM_ADDRESS, 2'(w)}] = MEM_WRITEDATA[w*8 +: 8];
            else           MEM_READDATA[w*8 +: 8] = bmem[{MEM_ADDRESS, 2'(w)}];
          end
        end else begin
          MEM_BUSYWAIT = 1'b1;
        end
      end else begin
        cnt = 0;
        MEM_BUSYWAIT = 1'b0;
      end
    end
  end

  // CPU-side monitor: every unstalled cycle either delivers an expected load or shows READDATA=0.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET === 1'b0 && BUSYWAIT === 1'b0) begin
        if (READ && !WRITE) begin
          if (exp_rd.size() == 0) fail("readdata_unexpected");
          else check("readdata", READDATA, exp_rd.pop_front());
        end else begin
          check("readdata_no_read", READDATA, 0);
        end
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input int l);
    logic [2:0] set, tag;
    bit         hit;
    int         exp_stall, stall;
    mem_ev_t    ev;
    @(posedge CLK);
    #1;
    lat = l;
    set = a[4:2];
    tag = a[7:5];
    hit = mvalid[set] && (mtag[set] == tag);
    exp_stall = 0;
    if (!hit) begin
      exp_stall = 2 + l;
      if (mvalid[set] && mdirty[set]) begin
        ev.is_wb = 1'b1;
        ev.addr  = {mtag[set], set};
        for (int w = 0; w < 4; w++) ev.data[w*8 +: 8] = ref_mem[{mtag[set], set, 2'(w)}];
        exp_mem.push_back(ev);
        exp_stall += l;
      end
      ev.is_wb = 1'b0;
      ev.addr  = {tag, set};
      ev.data  = '0;
      exp_mem.push_back(ev);
      mvalid[set] = 1'b1;
      mtag[set]   = tag;
      mdirty[set] = 1'b0;
      exp_misses++;
    end else begin
      exp_hits++;
    end
    if (wr) begin
      ref_mem[a]  = d;
      mdirty[set] = 1'b1;
    end else if (rd) begin
      exp_rd.push_back(ref_mem[a]);
    end
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    stall = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      stall++;
    end
    check($sformatf("stall_cycles_addr_%02h", a), stall, exp_stall);
  endtask

  task automatic idle_cycle();
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      mvalid[s] = 1'b0;
      mdirty[s] = 1'b0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = bmem[i];
    exp_hits = 0;
    exp_misses = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int op;
    logic [7:0] a;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      bmem[i]    = ref_mem[i];
    end
    bmem[8'h24] = 8'h11; bmem[8'h25] = 8'h22; bmem[8'h26] = 8'h33; bmem[8'h27] = 8'h44;
    model_reset();

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", BUSYWAIT, 0);
    check("reset_mem_read", MEM_READ, 0);
    check("reset_mem_write", MEM_WRITE, 0);
    check("reset_mem_address", MEM_ADDRESS, 0);
    check("reset_mem_writedata", MEM_WRITEDATA, 0);
    check("reset_readdata", READDATA, 0);
    check_stats("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Cold read miss, write hit, read-back hit.
    access(1, 0, 8'h25, 8'h00, 4);
    access(0, 1, 8'h26, 8'hAB, 2);
    access(1, 0, 8'h26, 8'h00, 2);
    check_stats("after_hits");
    // Dirty eviction of line 1, then a clean write miss and its later eviction.
    access(1, 0, 8'h65, 8'h00, 3);
    access(0, 1, 8'h80, 8'h5C, 2);
    access(1, 0, 8'h00, 8'h00, 1);
    idle_cycle();

    // Reset while the fetch for 0x25 is outstanding.
    @(posedge CLK);
    #1;
    lat = 4; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h25;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (MEM_READ === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("fetch_started_before_reset", got, 1);
    @(posedge CLK);
    #1;
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_mem_read", MEM_READ, 0);
    check("abort_mem_write", MEM_WRITE, 0);
    check("abort_busywait", BUSYWAIT, 0);
    exp_mem.delete();
    model_reset();
    check_stats("abort");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    access(1, 0, 8'h25, 8'h00, 2);

    // READ and WRITE together behave as a write.
    access(1, 1, 8'h27, 8'h5A, 1);
    access(1, 0, 8'h27, 8'h00, 1);

    for (int n = 0; n < 400; n++) begin
      a = {3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
      op = $urandom_range(0, 3);
      access(op != 2, op >= 2, a, 8'($urandom), $urandom_range(1, 4));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    idle_cycle();
    @(negedge CLK);
    check_stats("after_random");

`ifdef CACHE_STATS_EN
    // Hold a write hit long enough to drive the hit counter into saturation.
    access(0, 1, 8'h25, 8'h77, 1);
    repeat (65540) @(posedge CLK);
    exp_hits += 65539;
    #1;
    WRITE = 1'b0;
    @(negedge CLK);
    check_stats("saturation");
    access(1, 0, 8'h25, 8'h00, 1);
`endif

    idle_cycle();
    @(negedge CLK);
    check("exp_rd_drained", exp_rd.size(), 0);
    check("exp_mem_drained", exp_mem.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Parametrised direct-mapped, write-back, write-allocate data cache between the CPU memory port (READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT) and the block-wide data memory. Generalises the CPU's byte-wide single-access memory path to configurable data width, address width, set count and block size. It stalls the CPU via BUSYWAIT on misses and uses a multi-cycle FSM for write-back and refill.

## Interface
- DATA_W, 8, CPU word width in bits
- ADDR_W, 8, CPU byte-address width; word-addressed, one word per address
- NUM_SETS, 8, number of cache lines; power of 2, ≥2
- WORDS_PER_BLOCK, 4, words per line; power of 2, ≥2
- Derived: OFF_W=log2(WORDS_PER_BLOCK), IDX_W=log2(NUM_SETS), TAG_W=ADDR_W-IDX_W-OFF_W (must be ≥1)

Ports:
- CLK  in  1  clock
- RESET  in  1  reset; RESET, synchronous, active-high; clock CLK
- READ  in  1  CPU read request, held until BUSYWAIT low
- WRITE  in  1  CPU write request, held until BUSYWAIT low
- ADDRESS  in  ADDR_W  CPU word address {tag, index, offset}
- WRITEDATA  in  DATA_W  CPU store data
- READDATA  out  DATA_W  load data, valid when READ=1 and BUSYWAIT=0
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block write-back request
- MEM_ADDRESS  out  ADDR_W-OFF_W  block address {tag, index}
- MEM_WRITEDATA  out  DATA_W*WORDS_PER_BLOCK  victim block, word 0 in LSBs
- MEM_READDATA  in  DATA_W*WORDS_PER_BLOCK  fetched block
- MEM_BUSYWAIT  in  1  memory busy; transfer completes on first posedge with MEM_BUSYWAIT=0 while request is high
- HIT_COUNT, MISS_COUNT  out  16 each  present only with CACHE_STATS_EN

## Operation
- Per line: valid, dirty, tag, block. Hit = valid && stored tag == ADDRESS tag.
- FSM states: IDLE, WRITE_BACK, FETCH, FILL.
- IDLE: request (READ|WRITE) and hit → serve; miss and dirty → WRITE_BACK; miss and clean → FETCH.
- WRITE_BACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=victim block; MEM_BUSYWAIT low at posedge → FETCH.
- FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}; MEM_BUSYWAIT low at posedge → FILL, capturing MEM_READDATA.
- FILL: write block, set tag, valid=1, dirty=0 → IDLE; the access is then re-evaluated as a hit.
- Read hit: READDATA = block word[offset] combinationally; BUSYWAIT=0.
- Write hit: word[offset] ← WRITEDATA and dirty←1 at the posedge; BUSYWAIT=0.
- READ and WRITE both high: treated as WRITE.
- No request: READDATA=0, BUSYWAIT=0, no state change.
- Inputs (ADDRESS, WRITEDATA) must be stable while BUSYWAIT=1; the block does not latch them.

## Timing
- Reset: state IDLE, all valid/dirty=0, BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0, counters=0. Tag/data arrays are not cleared.
- RESET mid-miss aborts immediately. Memory requests drop next cycle and no line is updated.
- BUSYWAIT on miss is combinational in the request cycle. It stays high through WRITE_BACK/FETCH/FILL and falls in the IDLE cycle after FILL.
- Hit latency: 0 stall cycles. Clean miss: 1 (IDLE) + memory latency + 1 (FILL). Dirty miss adds the write-back latency.
- MEM_READ/MEM_WRITE are registered state decodes and are never high simultaneously.

## Configuration
- CACHE_STATS_EN defined: HIT_COUNT increments once per completed hit access. MISS_COUNT increments once per IDLE→WRITE_BACK/FETCH transition, so the post-FILL re-hit is not counted as a hit. Both counters saturate at 16'hFFFF.
- CACHE_STATS_EN undefined: counter ports and logic are absent.

## Structure
- Package dcache_pkg: FSM state enum (IDLE, WRITE_BACK, FETCH, FILL) and helper functions computing OFF_W/IDX_W/TAG_W.
- One sub-module, dcache_line_array: valid/dirty/tag/data storage with a single combinational read port, a word-write port and a block-fill port. The controller FSM stays in dcache_ctrl.

## Test plan
Defaults give tag=3b, index=3b, offset=2b.
- Cold read 0x25 (tag 1, idx 1, off 1), memory block 0x44332211 with 4-cycle MEM_BUSYWAIT → FETCH to block addr 0x09; READDATA=0x22; BUSYWAIT high 6 cycles; MISS_COUNT=1.
- Write 0xAB to 0x26 after the above → no stall; a subsequent read of 0x26 returns 0xAB; line 1 dirty; HIT_COUNT=2.
- Read 0x65 (tag 3, idx 1) → WRITE_BACK block addr 0x09 with data 0x44AB2211, then FETCH 0x19; MEM_READ and MEM_WRITE never overlap.
- Write miss to 0x80 (clean) → fetch, fill, then write word 0; line dirty; no write-back issued.
- RESET asserted during FETCH → next cycle MEM_READ=0, BUSYWAIT=0, state IDLE; re-reading 0x25 misses again.
- READ and WRITE both high at a hit address → the write is performed and no read-only behaviour occurs. With stats enabled, drive 65536+ hits → HIT_COUNT holds 0xFFFF.
